knn_sched: RTL and testbench
============================

# knn_sched

Run-level scheduler for the kNN classifier. It sequences the database loader into the systolic array once, then streams query vectors into the array with a credit limit. It captures the winning label after a fixed pipeline latency and returns results through a small output FIFO with a valid/ready handshake. It sits between the host-side query source and the db loader plus systolic array.

## Interface
- WORD_LEN, 6: bits per vector element
- LBL_LEN, 10: label width
- VECT_LEN, 4: elements per vector
- VECT_NUM, 35: array columns (database vectors); sets the reset default of PIPE_LAT
- PIPE_LAT, VECT_NUM+VECT_LEN: cycles from arr_qvalid high to the matching label on arr_lbl; must be ≥1
- OUT_DEPTH, 4: result FIFO depth and maximum outstanding queries; must be ≥1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a batch, honoured in IDLE only
- reload  in  1  pulse; marks the database stale, honoured in IDLE only
- q_valid  in  1  query present
- q_ready  out  1  query accepted when q_valid && q_ready at a rising edge
- q_data  in  VECT_LEN x WORD_LEN  query vector
- q_last  in  1  accepted query is the last one of the batch
- ld_ena  out  1  to loader enable
- ld_done  in  1  from loader; high while the loader is idle
- arr_qdata  out  VECT_LEN x WORD_LEN  query into the array
- arr_qvalid  out  1  arr_qdata valid, one cycle per query
- arr_lbl  in  LBL_LEN  nearest label from the array
- r_valid  out  1  result available
- r_ready  in  1  result consumed when r_valid && r_ready
- r_label  out  LBL_LEN  FIFO head label
- busy  out  1  state != IDLE
- batch_done  out  1  one-cycle pulse on DRAIN->IDLE

## Operation
- Internal `loaded` flag: cleared by reset and by reload; set when a load completes.
- IDLE: start && !loaded -> LOAD_REQ; start && loaded -> RUN. If reload and start arrive in the same cycle, reload clears `loaded` first, so the path is LOAD_REQ.
- LOAD_REQ: ld_ena=1 for exactly one cycle; clears `seen_busy`; -> LOAD_WAIT.
- LOAD_WAIT: ld_done==0 sets `seen_busy`. When `seen_busy` && ld_done: set `loaded`, -> RUN. A high ld_done before `seen_busy` is set is ignored.
- RUN: q_ready = (inflight + fifo_count < OUT_DEPTH). An accept with q_last -> DRAIN.
- DRAIN: q_ready=0. When inflight==0: pulse batch_done, -> IDLE. The FIFO need not be empty.
- Query path:
  - An accept registers q_data into arr_qdata; arr_qvalid=1 in the next cycle only.
  - arr_qdata holds its value between queries.
- Tag pipe: PIPE_LAT-stage shift of arr_qvalid. When the tap is high, arr_lbl is written to the FIFO.
- Counters:
  - inflight: +1 on accept, -1 on capture.
  - fifo_count: +1 on capture, -1 on pop.
  - Simultaneous events net out in one cycle.
  - The credit rule guarantees the FIFO never overflows. A capture into a full FIFO is impossible by construction.
- FIFO: circular, $clog2(OUT_DEPTH)-bit pointers wrapping at OUT_DEPTH. r_label shows the head. r_valid = fifo_count != 0. Results leave in query order.
- The loader and query traffic never overlap: q_ready=0 outside RUN.

## Timing
- Reset values: state IDLE, ld_ena 0, q_ready 0, arr_qvalid 0, arr_qdata 0, r_valid 0, r_label 0, busy 0, batch_done 0. `loaded` 0; inflight, fifo_count, pointers and tag pipe 0.
- Reset mid-load or mid-batch: everything returns to reset values on the next edge. In-flight and buffered results are discarded. The loader shares the same reset.
- Latency: accept at edge N -> arr_qvalid high in cycle N+1. Capture at edge N+1+PIPE_LAT. r_valid high in the following cycle if the FIFO was empty.
- Sustained throughput: 1 query/cycle when OUT_DEPTH > PIPE_LAT+1 and r_ready stays high. Otherwise the credit rule throttles q_ready.
- q_ready is combinational from state and counters only. It never depends on q_valid.
- start, reload and q_last are sampled only in the states listed above; they are ignored elsewhere.

## Test plan
- Cold start: reset, then start; model the loader with done dropping 1 cycle after ld_ena and rising 160 cycles later -> ld_ena is a single-cycle pulse, RUN is entered the cycle after done rises, and `loaded`=1.
- Warm start: a second start without reload -> IDLE->RUN directly, ld_ena stays 0.
- Streaming, r_ready=1, PIPE_LAT=39, OUT_DEPTH=4, 10 queries back-to-back:
  - q_ready deasserts after 4 accepts;
  - each r_valid occurs 41 cycles after its accept;
  - labels arrive in order;
  - batch_done pulses once, after the last capture.
- Backpressure: r_ready=0 until 4 results are buffered -> q_ready=0, no overflow. Raising r_ready for 1 cycle frees exactly one credit.
- Reload together with start -> the load sequence reruns. Reset asserted in LOAD_WAIT and in RUN with 3 queries in flight -> all outputs return to reset values, `loaded`=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/knn_sched.sv
// Run-level scheduler for the kNN classifier: loads the database once, streams
// credit-limited queries into the systolic array and buffers winning labels.
`timescale 1ns/1ps
module knn_sched #(
  parameter int WORD_LEN  = 6,
  parameter int LBL_LEN   = 10,
  parameter int VECT_LEN  = 4,
  parameter int VECT_NUM  = 35,
  parameter int PIPE_LAT  = VECT_NUM + VECT_LEN,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         reload,
  input  logic                         q_valid,
  output logic                         q_ready,
  input  logic [VECT_LEN*WORD_LEN-1:0] q_data,
  input  logic                         q_last,
  output logic                         ld_ena,
  input  logic                         ld_done,
  output logic [VECT_LEN*WORD_LEN-1:0] arr_qdata,
  output logic                         arr_qvalid,
  input  logic [LBL_LEN-1:0]           arr_lbl,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic [LBL_LEN-1:0]           r_label,
  output logic                         busy,
  output logic                         batch_done
);

  localparam int QW = VECT_LEN * WORD_LEN;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_WAIT,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic           loaded_q, loaded_d;
  logic           seen_busy_q, seen_busy_d;
  logic [QW-1:0]  arr_qdata_q, arr_qdata_d;
  logic           arr_qvalid_q, arr_qvalid_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_count_q, fifo_count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LBL_LEN-1:0] mem_q [OUT_DEPTH];

  logic           accept, capture, pop, credit_ok;
  logic [CW:0]    used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count both results still in the array and results parked in the
  // FIFO, so a capture always finds a free slot.
  assign used      = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign credit_ok = used < (CW+1)'(OUT_DEPTH);
  assign capture   = tag_q[PIPE_LAT-1];
  assign pop       = r_valid && r_ready;
  assign accept    = q_valid && q_ready;

  assign busy       = (state_q != S_IDLE);
  assign arr_qdata  = arr_qdata_q;
  assign arr_qvalid = arr_qvalid_q;
  assign r_valid    = (fifo_count_q != '0);
  // Gating the head with r_valid gives a zero label out of reset without
  // having to clear the storage.
  assign r_label    = r_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d      = state_q;
    loaded_d     = loaded_q;
    seen_busy_d  = seen_busy_q;
    ld_ena       = 1'b0;
    batch_done   = 1'b0;
    q_ready      = (state_q == S_RUN) && credit_ok;
    arr_qvalid_d = accept;
    arr_qdata_d  = accept ? q_data : arr_qdata_q;
    tag_d        = PIPE_LAT'({tag_q, arr_qvalid_q});
    wr_ptr_d     = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({capture, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (reload) loaded_d = 1'b0;
        // A reload in the same cycle as start wins, forcing a fresh load.
        if (start) state_d = (loaded_q && !reload) ? S_RUN : S_LOAD_REQ;
      end
      S_LOAD_REQ: begin
        ld_ena      = 1'b1;
        seen_busy_d = 1'b0;
        state_d     = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        // ld_done only counts once the loader has been seen busy.
        if (seen_busy_q && ld_done) begin
          loaded_d = 1'b1;
          state_d  = S_RUN;
        end else if (!ld_done) begin
          seen_busy_d = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && q_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (inflight_q == '0) begin
          batch_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      loaded_q     <= 1'b0;
      seen_busy_q  <= 1'b0;
      arr_qdata_q  <= '0;
      arr_qvalid_q <= 1'b0;
      tag_q        <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      seen_busy_q  <= seen_busy_d;
      arr_qdata_q  <= arr_qdata_d;
      arr_qvalid_q <= arr_qvalid_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // NOTE: the label storage is intentionally not reset; fifo_count and the
  // r_label gate make stale entries unobservable.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= arr_lbl;
  end

endmodule

// File: tb/tb_knn_sched.sv
// Self-checking bench for knn_sched: a queue-based transaction model predicts
// every output each cycle, plus hand-computed checks on key timings.
`timescale 1ns/1ps
module tb_knn_sched;

  localparam int WORD_LEN  = 6;
  localparam int LBL_LEN   = 10;
  localparam int VECT_LEN  = 4;
  localparam int VECT_NUM  = 35;
  localparam int PIPE_LAT  = VECT_NUM + VECT_LEN;
  localparam int OUT_DEPTH = 4;
  localparam int QW        = VECT_LEN * WORD_LEN;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, reload = 1'b0;
  logic q_valid = 1'b0, q_last = 1'b0, ld_done = 1'b1, r_ready = 1'b0;
  logic [QW-1:0]      q_data = '0;
  logic [LBL_LEN-1:0] arr_lbl = '0;
  logic               q_ready, ld_ena, arr_qvalid, r_valid, busy, batch_done;
  logic [QW-1:0]      arr_qdata;
  logic [LBL_LEN-1:0] r_label;

  knn_sched #(
    .WORD_LEN(WORD_LEN), .LBL_LEN(LBL_LEN), .VECT_LEN(VECT_LEN),
    .VECT_NUM(VECT_NUM), .PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .reload(reload),
    .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_last(q_last),
    .ld_ena(ld_ena), .ld_done(ld_done),
    .arr_qdata(arr_qdata), .arr_qvalid(arr_qvalid), .arr_lbl(arr_lbl),
    .r_valid(r_valid), .r_ready(r_ready), .r_label(r_label),
    .busy(busy), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int bd_cnt  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Label the array model returns for a query; junk labels use a disjoint range.
  function automatic logic [LBL_LEN-1:0] lbl_of(input logic [QW-1:0] d);
    return {2'b01, d[7:0] ^ d[23:16]};
  endfunction

  function automatic logic [QW-1:0] qv(input int k);
    return 24'h123456 + 24'(k) * 24'h0F1E2D;
  endfunction

  // ---------------- transaction model ----------------
  typedef enum {P_IDLE, P_LOAD_REQ, P_LOAD_WAIT, P_RUN, P_DRAIN} phase_t;
  typedef struct {
    int                 cap;
    logic [LBL_LEN-1:0] lbl;
  } pend_t;

  phase_t             m_phase  = P_IDLE;
  bit                 m_loaded = 1'b0;
  bit                 m_seen   = 1'b0;
  bit                 m_acc    = 1'b0;
  bit                 m_arr_v  = 1'b0;
  logic [QW-1:0]      m_arr_d  = '0;
  pend_t              pend[$];
  logic [LBL_LEN-1:0] fifo[$];

  always @(posedge clk) begin
    int    pend_n, fifo_n;
    bit    acc, pop, cap;
    pend_t p;
    cyc++;
    if (reset) begin
      m_phase = P_IDLE; m_loaded = 1'b0; m_seen = 1'b0; m_acc = 1'b0;
      m_arr_v = 1'b0;   m_arr_d = '0;
      pend.delete();    fifo.delete();
    end else begin
      pend_n = pend.size();
      fifo_n = fifo.size();
      acc = (m_phase == P_RUN) && (pend_n + fifo_n < OUT_DEPTH) && q_valid;
      pop = r_ready && (fifo_n != 0);
      cap = (pend_n != 0) && (pend[0].cap == cyc);
      if (pop) void'(fifo.pop_front());
      if (cap) begin
        fifo.push_back(pend[0].lbl);
        void'(pend.pop_front());
      end
      if (acc) begin
        p.cap = cyc + 1 + PIPE_LAT;
        p.lbl = lbl_of(q_data);
        pend.push_back(p);
        m_arr_d = q_data;
      end
      m_arr_v = acc;
      m_acc   = acc;
      case (m_phase)
        P_IDLE: begin
          if (reload) m_loaded = 1'b0;
          if (start) m_phase = m_loaded ? P_RUN : P_LOAD_REQ;
        end
        P_LOAD_REQ: begin m_seen = 1'b0; m_phase = P_LOAD_WAIT; end
        P_LOAD_WAIT: begin
          if (m_seen && ld_done) begin m_loaded = 1'b1; m_phase = P_RUN; end
          else if (!ld_done) m_seen = 1'b1;
        end
        P_RUN:   if (acc && q_last) m_phase = P_DRAIN;
        P_DRAIN: if (pend_n == 0) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Compare every output each cycle, then present the array's label for the
  // next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ld_ena",     32'(ld_ena),     32'(m_phase == P_LOAD_REQ));
      check("q_ready",    32'(q_ready),    32'((m_phase == P_RUN) && (pend.size() + fifo.size() < OUT_DEPTH)));
      check("arr_qvalid", 32'(arr_qvalid), 32'(m_arr_v));
      check("arr_qdata",  32'(arr_qdata),  32'(m_arr_d));
      check("r_valid",    32'(r_valid),    32'(fifo.size() != 0));
      check("r_label",    32'(r_label),    (fifo.size() != 0) ? 32'(fifo[0]) : 32'd0);
      check("busy",       32'(busy),       32'(m_phase != P_IDLE));
      check("batch_done", 32'(batch_done), 32'((m_phase == P_DRAIN) && (pend.size() == 0)));
      if (batch_done === 1'b1) bd_cnt++;
    end
    if (pend.size() != 0 && pend[0].cap == cyc + 1) arr_lbl = pend[0].lbl;
    else                                           arr_lbl = {2'b11, 8'(cyc)};
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_q(input int n, input bit last, input int base);
    int budget;
    for (int i = 0; i < n; i++) begin
      q_valid = 1'b1;
      q_data  = qv(base + i);
      q_last  = last && (i == n - 1);
      budget  = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!m_acc && budget < 400);
      if (!m_acc) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: query %0d of base %0d not accepted in 400 cycles", i, base);
        break;
      end
    end
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while (!(m_phase == P_IDLE && fifo.size() == 0) && b < 600) begin
      @(negedge clk);
      b++;
    end
    if (!(m_phase == P_IDLE && fifo.size() == 0)) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: batch did not finish in 600 cycles");
    end
  endtask

  task automatic do_load(input int hi, input int lo);
    @(negedge clk);
    repeat (hi) @(negedge clk);
    ld_done = 1'b0;
    repeat (lo) @(negedge clk);
    ld_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ld_ena"},     32'(ld_ena),     32'd0);
    check({tag, "_q_ready"},    32'(q_ready),    32'd0);
    check({tag, "_arr_qvalid"}, 32'(arr_qvalid), 32'd0);
    check({tag, "_arr_qdata"},  32'(arr_qdata),  32'd0);
    check({tag, "_r_valid"},    32'(r_valid),    32'd0);
    check({tag, "_r_label"},    32'(r_label),    32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_batch_done"}, 32'(batch_done), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_reset_vals("por");
    reset = 1'b0;

    // Cold start with the loader busy for 160 cycles.
    pulse_start();
    check("cold_ld_ena_hi", 32'(ld_ena), 32'd1);
    @(negedge clk);
    check("cold_ld_ena_lo", 32'(ld_ena), 32'd0);
    ld_done = 1'b0;
    repeat (160) @(negedge clk);
    check("cold_wait_qready", 32'(q_ready), 32'd0);
    ld_done = 1'b1;
    @(negedge clk);
    check("cold_run_entered", 32'(q_ready), 32'd1);
    r_ready = 1'b1;
    send_q(2, 1'b1, 100);
    wait_idle();

    // Warm start and streaming of 10 queries.
    pulse_start();
    check("warm_no_ld_ena", 32'(ld_ena), 32'd0);
    check("warm_run", 32'(q_ready), 32'd1);
    bd0 = bd_cnt;
    fork
      send_q(10, 1'b1, 0);
      begin
        @(negedge clk);
        check("stream_arr_qvalid", 32'(arr_qvalid), 32'd1);
        check("stream_arr_qdata",  32'(arr_qdata),  32'h123456);
        repeat (2) @(negedge clk);
        check("stream_qready_3acc", 32'(q_ready), 32'd1);
        @(negedge clk);
        check("stream_qready_4acc", 32'(q_ready), 32'd0);
        repeat (36) @(negedge clk);
        check("stream_rvalid_early", 32'(r_valid), 32'd0);
        @(negedge clk);
        check("stream_rvalid_41", 32'(r_valid), 32'd1);
        check("stream_label0",    32'(r_label), 32'h144);
      end
    join
    wait_idle();
    check("stream_one_batch_done", 32'(bd_cnt - bd0), 32'd1);

    // Backpressure: FIFO fills, one pop frees exactly one credit.
    r_ready = 1'b0;
    pulse_start();
    fork
      send_q(6, 1'b1, 20);
      begin
        repeat (60) @(negedge clk);
        check("bp_full_qready", 32'(q_ready), 32'd0);
        check("bp_full_rvalid", 32'(r_valid), 32'd1);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("bp_credit_freed", 32'(q_ready), 32'd1);
        @(negedge clk);
        check("bp_credit_used", 32'(q_ready), 32'd0);
        repeat (3) @(negedge clk);
        r_ready = 1'b1;
      end
    join
    wait_idle();

    // Reload with start; early ld_done is ignored; reset lands in LOAD_WAIT.
    reload = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    start  = 1'b0;
    check("reload_ld_ena", 32'(ld_ena), 32'd1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reload_done_ignored", 32'(busy), 32'd1);
    ld_done = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    ld_done = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_load");
    reset = 1'b0;

    // Loaded flag was cleared, so start loads again; reset with 3 in flight.
    pulse_start();
    check("rst_reload_ld_ena", 32'(ld_ena), 32'd1);
    do_load(1, 5);
    check("reload_run", 32'(q_ready), 32'd1);
    send_q(3, 1'b0, 40);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_run");
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("no_stale_result", 32'(r_valid), 32'd0);

    pulse_start();
    check("final_ld_ena", 32'(ld_ena), 32'd1);
    do_load(0, 4);
    send_q(2, 1'b1, 60);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
